four_to_two_encoder: RTL and testbench

FOUR_TO_TWO_ENCODER -- requirements
Module: four_to_two_encoder

---
 rtl/encoder_pkg.sv | 8 +
 rtl/rr_pick.sv | 20 ++
 rtl/four_to_two_encoder.sv | 57 +++++
 tb/tb_four_to_two_encoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared sizes and helpers for the four-to-two encoder slice.
package encoder_pkg;
    localparam int REQ_N = 4;
    localparam int CODE_W = 2;
    function automatic logic [2:0] popcount4(input logic [REQ_N-1:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks the first asserted request searching upward from ptr, wrapping mod 4.
module rr_pick
    import encoder_pkg::*;
(
    input  logic [REQ_N-1:0]  req,
    input  logic [CODE_W-1:0] ptr,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    logic [2*REQ_N-1:0] dbl;
    logic [REQ_N-1:0] rot;
    logic [CODE_W-1:0] off;
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[REQ_N-1:0];
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        idx = ptr + off;
        any = |req;
    end
endmodule

// File: rtl/four_to_two_encoder.sv
// four_to_two_encoder: registered 4:2 priority encoder with valid/ready hand-off,
// optional rotating priority, one-shot grant and accepted-code counter.
module four_to_two_encoder
    import encoder_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             D0,
    input  logic             D1,
    input  logic             D2,
    input  logic             D3,
    input  logic             READY,
    output logic             S0,
    output logic             S1,
    output logic             VALID,
    output logic             MULTI,
    output logic [REQ_N-1:0] GRANT,
    output logic [CNT_W-1:0] CNT
);
    logic [REQ_N-1:0] d;
    logic [CODE_W-1:0] ptr, pick_ptr, idx;
    logic any, open;
    always_comb begin
        d = {D3, D2, D1, D0};
        pick_ptr = (ROUND_ROBIN != 0) ? ptr : '0;
        open = !VALID || READY;
    end
    rr_pick u_pick (.req(d), .ptr(pick_ptr), .idx(idx), .any(any));
    // A full slot with READY low freezes everything except the grant pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            {S1, S0} <= '0;
            VALID <= 1'b0;
            MULTI <= 1'b0;
            GRANT <= '0;
            CNT <= '0;
            ptr <= '0;
        end else begin
            GRANT <= '0;
            if (VALID && READY) CNT <= CNT + 1'b1;
            if (open) begin
                if (any) begin
                    {S1, S0} <= idx;
                    VALID <= 1'b1;
                    MULTI <= popcount4(d) > 3'd1;
                    GRANT <= REQ_N'(1) << idx;
                    if (ROUND_ROBIN != 0) ptr <= idx + 2'd1;
                end else begin
                    VALID <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_four_to_two_encoder.sv
// tb_four_to_two_encoder: rotating and fixed-priority instances checked against a
// behavioural model every cycle, plus directed literal checks.
module tb_four_to_two_encoder;
    logic clk = 0, rst = 1, ready = 0, chk_en = 0;
    logic [3:0] d = 0;
    logic [1:0] s0, s1, valid, multi;
    logic [3:0] grant [2];
    logic [3:0] cnt [2];
    int tests = 0, fails = 0;
    int m_valid [2], m_code [2], m_multi [2], m_grant [2], m_cnt [2], m_ptr [2];

    always #5 clk = ~clk;

    four_to_two_encoder #(.ROUND_ROBIN(1), .CNT_W(4)) dut_rr (
        .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .READY(ready),
        .S0(s0[0]), .S1(s1[0]), .VALID(valid[0]), .MULTI(multi[0]), .GRANT(grant[0]), .CNT(cnt[0]));
    four_to_two_encoder #(.ROUND_ROBIN(0), .CNT_W(4)) dut_fp (
        .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .READY(ready),
        .S0(s0[1]), .S1(s1[1]), .VALID(valid[1]), .MULTI(multi[1]), .GRANT(grant[1]), .CNT(cnt[1]));

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int first_set(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    // Reference model: u=0 rotating priority, u=1 fixed priority.
    always @(posedge clk) begin
        int k;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_valid[u] = 0; m_code[u] = 0; m_multi[u] = 0; m_grant[u] = 0; m_cnt[u] = 0; m_ptr[u] = 0;
            end else begin
                m_grant[u] = 0;
                if (m_valid[u] != 0 && ready) m_cnt[u] = (m_cnt[u] + 1) % 16;
                if (m_valid[u] == 0 || ready) begin
                    k = first_set(d, u == 0 ? m_ptr[u] : 0);
                    if (k < 0) m_valid[u] = 0;
                    else begin
                        m_code[u] = k;
                        m_valid[u] = 1;
                        m_multi[u] = ($countones(d) > 1) ? 1 : 0;
                        m_grant[u] = 1 << k;
                        m_ptr[u] = (u == 0) ? (k + 1) % 4 : 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
            string t;
            t = (u == 0) ? "rr" : "fp";
            chk({"valid_", t}, int'(valid[u]), m_valid[u]);
            chk({"code_", t}, int'({s1[u], s0[u]}), m_code[u]);
            chk({"multi_", t}, int'(multi[u]), m_multi[u]);
            chk({"grant_", t}, int'(grant[u]), m_grant[u]);
            chk({"cnt_", t}, int'(cnt[u]), m_cnt[u]);
        end
    end

    task automatic step(input logic [3:0] dv, input logic r);
        d = dv;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};
        rst = 1;
        step(4'b1111, 1);
        chk_en = 1;
        step(4'b1111, 1);
        for (int u = 0; u < 2; u++) begin
            chk("reset_valid", int'(valid[u]), 0);
            chk("reset_code", int'({s1[u], s0[u]}), 0);
            chk("reset_grant", int'(grant[u]), 0);
            chk("reset_cnt", int'(cnt[u]), 0);
        end
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            step(4'(1 << k), 1);
            chk("single_code", int'({s1[0], s0[0]}), k);
            chk("single_grant", int'(grant[0]), 1 << k);
            chk("single_multi", int'(multi[0]), 0);
        end
        step(4'b0000, 1);
        chk("single_cnt", int'(cnt[0]), 4);
        chk("single_idle", int'(valid[0]), 0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1);
            chk("rot_code_rr", int'({s1[0], s0[0]}), exp_rr[i]);
            chk("rot_multi_rr", int'(multi[0]), 1);
            chk("rot_code_fp", int'({s1[1], s0[1]}), 0);
        end
        step(4'b0000, 1);
        chk("rot_cnt", int'(cnt[0]), 9);
        step(4'b0100, 1);
        chk("bp_capture", int'({s1[0], s0[0]}), 2);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 0);
            chk("bp_hold_code", int'({s1[0], s0[0]}), 2);
            chk("bp_hold_grant", int'(grant[0]), 0);
            chk("bp_hold_valid", int'(valid[0]), 1);
        end
        step(4'b0001, 1);
        chk("bp_release_cnt", int'(cnt[0]), 10);
        chk("bp_release_code", int'({s1[0], s0[0]}), 0);
        for (int i = 0; i < 6; i++) step(4'b0001, 1);
        chk("wrap_cnt", int'(cnt[0]), 0);
        step(4'b1000, 1);
        chk("wrap_d3", int'({s1[0], s0[0]}), 3);
        step(4'b1111, 1);
        chk("wrap_ptr", int'({s1[0], s0[0]}), 0);
        step(4'b0100, 1);
        step(4'b0001, 0);
        chk("mid_valid_before", int'(valid[0]), 1);
        rst = 1;
        step(4'b0001, 0);
        rst = 0;
        chk("mid_valid", int'(valid[0]), 0);
        chk("mid_cnt", int'(cnt[0]), 0);
        step(4'b1010, 1);
        chk("mid_code_rr", int'({s1[0], s0[0]}), 1);
        chk("mid_code_fp", int'({s1[1], s0[1]}), 1);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(49) == 0);
            step(4'($urandom_range(15)), $urandom_range(3) != 0);
        end
        rst = 0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
